// File: rtl/chrom_eval_ctrl_if.sv
// chrom_eval_ctrl_if
//   HPS <-> FPGA chromosome-evaluation handshake and data bus.
//   master: HPS side (drives start/feedback, sequence count and sequence words).
//   slave : evaluation controller (drives error sums, done and ready).
//   Signals:
//     start_processing_chrom    HPS request, level
//     done_processing_feedback  HPS ack of done, level
//     sequences_to_process      number of sequences to apply
//     input_sequence            word i bit s = circuit input i for sequence s
//     expected_output           word o bit s = expected output o for sequence s
//     valid_output              word o bit s = 1: compare output o for sequence s
//     error_sum                 word o = mismatch count for output o
//     done_processing_chrom     results valid, level
//     ready_to_process          controller idle, may accept start
interface chrom_eval_ctrl_if #(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 5
);
  logic                    start_processing_chrom;
  logic                    done_processing_feedback;
  logic [31:0]             sequences_to_process;
  logic [NUM_IN*32-1:0]    input_sequence;
  logic [NUM_OUT*32-1:0]   expected_output;
  logic [NUM_OUT*32-1:0]   valid_output;
  logic [NUM_OUT*32-1:0]   error_sum;
  logic                    done_processing_chrom;
  logic                    ready_to_process;

  modport master (
    output start_processing_chrom,
    output done_processing_feedback,
    output sequences_to_process,
    output input_sequence,
    output expected_output,
    output valid_output,
    input  error_sum,
    input  done_processing_chrom,
    input  ready_to_process
  );

  modport slave (
    input  start_processing_chrom,
    input  done_processing_feedback,
    input  sequences_to_process,
    input  input_sequence,
    input  expected_output,
    input  valid_output,
    output error_sum,
    output done_processing_chrom,
    output ready_to_process
  );
endinterface

// File: rtl/chrom_eval_ctrl.sv
// chrom_eval_ctrl
//   Applies each HPS-loaded test sequence to the evolved circuit, waits
//   SETTLE_CYCLES for it to settle, samples the response and accumulates
//   per-output masked mismatch counts. Results are then reported through a
//   four-phase done/feedback handshake.
//   Ports:
//     clk_clk        in   system clock
//     reset_reset_n  in   async active-low reset
//     hps            slave side of the HPS handshake/data bus
//     circ_in        out  stimulus to the evaluated circuit
//     circ_out       in   response of the evaluated circuit
module chrom_eval_ctrl #(
  parameter int NUM_IN        = 5,
  parameter int NUM_OUT       = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  chrom_eval_ctrl_if.slave   hps,
  output logic [NUM_IN-1:0]  circ_in,
  input  logic [NUM_OUT-1:0] circ_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  logic [2:0]     state;
  logic [5:0]     n_lat;
  logic [4:0]     seq_idx;
  logic [CW-1:0]  cnt;
  logic [31:0]    err [NUM_OUT];
  logic           done_q;

  logic [31:0]        in_word  [NUM_IN];
  logic [31:0]        exp_word [NUM_OUT];
  logic [31:0]        val_word [NUM_OUT];
  logic [NUM_IN-1:0]  first_bits;
  logic [NUM_IN-1:0]  next_bits;
  logic [NUM_OUT-1:0] mismatch;
  logic [4:0]         next_idx;
  logic [5:0]         n_clamped;
  logic               last_seq;

  always_comb begin
    next_idx  = seq_idx + 5'd1;
    n_clamped = (hps.sequences_to_process > 32'd32) ? 6'd32
                                                    : hps.sequences_to_process[5:0];
    last_seq  = ({1'b0, seq_idx} == (n_lat - 6'd1));
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_word[i]    = hps.input_sequence[i*32 +: 32];
      first_bits[i] = in_word[i][0];
      next_bits[i]  = in_word[i][next_idx];
    end
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      exp_word[o] = hps.expected_output[o*32 +: 32];
      val_word[o] = hps.valid_output[o*32 +: 32];
      mismatch[o] = (circ_out[o] ^ exp_word[o][seq_idx]) & val_word[o][seq_idx];
    end
  end

  always_comb begin
    hps.error_sum = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++)
      hps.error_sum[o*32 +: 32] = err[o];
  end

  assign hps.ready_to_process      = (state == S_IDLE);
  assign hps.done_processing_chrom = done_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= S_IDLE;
      n_lat   <= '0;
      seq_idx <= '0;
      cnt     <= '0;
      circ_in <= '0;
      done_q  <= 1'b0;
      for (int unsigned o = 0; o < NUM_OUT; o++) err[o] <= '0;
    end else begin
      // done is registered off the state, so it appears one cycle after
      // DONE is entered and drops on the same edge that leaves for ACK.
      done_q <= (state == S_DONE) && !hps.done_processing_feedback;

      case (state)
        S_IDLE: begin
          if (hps.start_processing_chrom) begin
            for (int unsigned o = 0; o < NUM_OUT; o++) err[o] <= '0;
            n_lat   <= n_clamped;
            seq_idx <= '0;
            cnt     <= '0;
            if (n_clamped == 6'd0) begin
              circ_in <= '0;
              state   <= S_DONE;
            end else begin
              circ_in <= first_bits;
              state   <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (cnt == CNT_LAST) state <= S_SAMPLE;
          else                 cnt   <= cnt + CW'(1);
        end

        S_SAMPLE: begin
          for (int unsigned o = 0; o < NUM_OUT; o++)
            err[o] <= err[o] + 32'(mismatch[o]);
          if (last_seq) begin
            state <= S_DONE;
          end else begin
            seq_idx <= next_idx;
            circ_in <= next_bits;
            cnt     <= '0;
            state   <= S_SETTLE;
          end
        end

        S_DONE: begin
          if (hps.done_processing_feedback) state <= S_ACK;
        end

        S_ACK: begin
          // A start still held from the previous run must drop before re-arming.
          if (!hps.done_processing_feedback && !hps.start_processing_chrom)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chrom_eval_ctrl.sv
// tb_chrom_eval_ctrl
//   Directed self-checking bench for chrom_eval_ctrl (NUM_IN=NUM_OUT=5,
//   SETTLE_CYCLES=4). The evaluated circuit is either a loopback of circ_in
//   or a constant all-ones response.
module tb_chrom_eval_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] circ_in;
  logic [4:0] circ_out;
  logic       ones_mode;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_err [5];
  logic [4:0]  circ_s0;
  logic [4:0]  circ_s1;

  chrom_eval_ctrl_if #(.NUM_IN(5), .NUM_OUT(5)) hps ();

  chrom_eval_ctrl #(
    .NUM_IN(5),
    .NUM_OUT(5),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .hps           (hps),
    .circ_in       (circ_in),
    .circ_out      (circ_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb circ_out = ones_mode ? 5'h1F : circ_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_sums(input string tag);
    for (int o = 0; o < 5; o++)
      check_val($sformatf("%s_err%0d", tag, o), hps.error_sum[o*32 +: 32], exp_err[o]);
  endtask

  task automatic clear_exp();
    for (int o = 0; o < 5; o++) exp_err[o] = '0;
  endtask

  // Raises start for one sampling edge (or keeps it high when hold is set)
  // and measures the cycles from that edge until done is seen.
  task automatic run_chrom(input logic [31:0] n, input int lat_exp, input bit hold,
                           input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    hps.sequences_to_process   = n;
    hps.start_processing_chrom = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_ready_low"}, 32'(hps.ready_to_process), 32'd0);
    circ_s0 = circ_in;
    if (!hold) hps.start_processing_chrom = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) circ_s1 = circ_in;
      if (hps.done_processing_chrom) seen = 1'b1;
    end
    check_val({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
  endtask

  task automatic ack_done(input string tag);
    @(negedge clk);
    hps.done_processing_feedback = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_done_dropped"}, 32'(hps.done_processing_chrom), 32'd0);
    @(negedge clk);
    hps.done_processing_feedback = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_ready_back"}, 32'(hps.ready_to_process), 32'd1);
  endtask

  initial begin
    rst_n                        = 1'b0;
    ones_mode                    = 1'b0;
    hps.start_processing_chrom   = 1'b0;
    hps.done_processing_feedback = 1'b0;
    hps.sequences_to_process     = '0;
    hps.input_sequence           = '0;
    hps.expected_output          = '0;
    hps.valid_output             = '0;
    clear_exp();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(hps.ready_to_process), 32'd1);
    check_val("rst_done", 32'(hps.done_processing_chrom), 32'd0);
    check_val("rst_circ_in", 32'(circ_in), 32'd0);
    check_sums("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Loopback, expected = inputs, all valid: no errors, 4*5+1 cycles.
    // Seq 0 bits {w4..w0} = 1,0,1,0,1 ; seq 1 bits = 1,0,0,1,0.
    hps.input_sequence  = {32'hF, 32'h8, 32'h5, 32'h2, 32'h1};
    hps.expected_output = {32'hF, 32'h8, 32'h5, 32'h2, 32'h1};
    hps.valid_output    = '1;
    clear_exp();
    run_chrom(32'd4, 21, 1'b0, "loop");
    check_val("loop_circ_s0", 32'(circ_s0), 32'h15);
    check_val("loop_circ_s1", 32'(circ_s1), 32'h12);
    check_sums("loop");
    ack_done("loop");

    // Output 2 expected all-zero while w2 = 0101: mismatches at seq 0 and 2.
    hps.expected_output = {32'hF, 32'h8, 32'h0, 32'h2, 32'h1};
    clear_exp();
    exp_err[2] = 32'd2;
    run_chrom(32'd4, 21, 1'b0, "loop2");
    check_sums("loop2");
    ack_done("loop2");

    // Output 0 always 1 against expected 0, all 32 sequences valid.
    ones_mode           = 1'b1;
    hps.expected_output = '0;
    hps.valid_output    = '0;
    hps.valid_output[0*32 +: 32] = 32'hFFFF_FFFF;
    clear_exp();
    exp_err[0] = 32'd32;
    run_chrom(32'd32, 161, 1'b0, "full32");
    check_sums("full32");
    ack_done("full32");

    // Count above 32 clamps to 32 sequences.
    hps.valid_output = '0;
    hps.valid_output[3*32 +: 32] = 32'hFFFF_FFFF;
    clear_exp();
    exp_err[3] = 32'd32;
    run_chrom(32'd40, 161, 1'b0, "clamp");
    check_sums("clamp");
    ack_done("clamp");

    // Only the first 4 of 8 sequences are valid on output 1.
    hps.valid_output = '0;
    hps.valid_output[1*32 +: 32] = 32'h0000_000F;
    clear_exp();
    exp_err[1] = 32'd4;
    run_chrom(32'd8, 41, 1'b0, "mask");
    check_sums("mask");
    ack_done("mask");

    // Zero sequences: done one cycle after start, sums cleared, circ_in idle.
    clear_exp();
    run_chrom(32'd0, 1, 1'b0, "zero");
    check_sums("zero");
    check_val("zero_circ_in", 32'(circ_in), 32'd0);
    ack_done("zero");

    // Start held through the handshake must not retrigger.
    hps.valid_output = '0;
    hps.valid_output[4*32 +: 32] = 32'hFFFF_FFFF;
    clear_exp();
    exp_err[4] = 32'd2;
    run_chrom(32'd2, 11, 1'b1, "hold");
    check_sums("hold");
    @(negedge clk);
    hps.done_processing_feedback = 1'b1;
    @(posedge clk); #1;
    check_val("hold_done_dropped", 32'(hps.done_processing_chrom), 32'd0);
    @(negedge clk);
    hps.done_processing_feedback = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_ready_low", 32'(hps.ready_to_process), 32'd0);
    check_val("hold_no_done", 32'(hps.done_processing_chrom), 32'd0);
    check_sums("hold_kept");
    @(negedge clk);
    hps.start_processing_chrom = 1'b0;
    @(posedge clk); #1;
    check_val("hold_ready_back", 32'(hps.ready_to_process), 32'd1);

    // Reset during SETTLE of sequence 3, then a clean rerun.
    hps.valid_output = '0;
    hps.valid_output[1*32 +: 32] = 32'h0000_000F;
    @(negedge clk);
    hps.sequences_to_process   = 32'd8;
    hps.start_processing_chrom = 1'b1;
    @(posedge clk); #1;
    hps.start_processing_chrom = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_val("rstmid_partial", hps.error_sum[1*32 +: 32], 32'd3);
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_val("rstmid_ready", 32'(hps.ready_to_process), 32'd1);
    check_val("rstmid_done", 32'(hps.done_processing_chrom), 32'd0);
    check_val("rstmid_circ_in", 32'(circ_in), 32'd0);
    check_sums("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    exp_err[1] = 32'd4;
    run_chrom(32'd8, 41, 1'b0, "rerun");
    check_sums("rerun");
    ack_done("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
